// File: rtl/dwb_pkg.sv
// Shared types and widths for the D-cache write buffer.
// Line-granular: one entry holds one 128-bit line.
package dwb_pkg;

    localparam int LINE_W  = 128;
    localparam int LADDR_W = 28;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic               valid;
        logic [LADDR_W-1:0] addr;
        logic [LINE_W-1:0]  data;
    } entry_t;

endpackage

// File: rtl/dwb_store.sv
// Circular FIFO of buffered dirty lines.
// Provides push/pop/overwrite and a combinational address match.
module dwb_store
    import dwb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic [LADDR_W-1:0] i_push_addr,
    input  logic [LINE_W-1:0]  i_push_data,
    input  logic               i_pop,
    input  logic               i_ovr,
    input  logic [PW-1:0]      i_ovr_idx,
    input  logic [LINE_W-1:0]  i_ovr_data,
    input  logic [LADDR_W-1:0] i_match_addr,
    output logic               o_hit,
    output logic [PW-1:0]      o_hit_idx,
    output logic [LINE_W-1:0]  o_hit_data,
    output logic [LADDR_W-1:0] o_head_addr,
    output logic [LINE_W-1:0]  o_head_data,
    output logic               o_full,
    output logic               o_empty
);

    entry_t          r_ent [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   w_idx;
    logic            w_hit;

    // Addresses are unique thanks to coalescing, so at most one entry matches
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_ent[i].valid && (r_ent[i].addr == i_match_addr)) begin
                w_hit = 1'b1;
                w_idx = PW'(i);
            end
        end
    end

    assign o_hit       = w_hit;
    assign o_hit_idx   = w_idx;
    assign o_hit_data  = r_ent[w_idx].data;
    assign o_head_addr = r_ent[r_head].addr;
    assign o_head_data = r_ent[r_head].data;
    assign o_full      = (r_count == CW'(DEPTH));
    assign o_empty     = (r_count == '0);

    // Entry array: coalesce, append at tail, invalidate head on drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else begin
            if (i_ovr) begin
                r_ent[i_ovr_idx].data <= i_ovr_data;
            end
            if (i_push) begin
                r_ent[r_tail] <= '{valid: 1'b1,
                                   addr:  i_push_addr,
                                   data:  i_push_data};
            end
            if (i_pop) begin
                r_ent[r_head].valid <= 1'b0;
            end
        end
    end

    // Head/tail pointers wrap naturally at a power-of-two depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (i_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (i_pop && !i_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_write_buffer.sv
// Write buffer between the D-cache port and slow memory.
// Writes complete in one cycle; buffered lines drain in the background.
module dcache_write_buffer
    import dwb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cache_read,
    input  logic         cache_write,
    input  logic [27:0]  cache_addr,
    input  logic [127:0] cache_wdata,
    output logic [127:0] cache_rdata,
    output logic         cache_ready,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    localparam int PW = $clog2(DEPTH);

    state_t              r_state;
    logic                r_cache_ready;
    logic [LINE_W-1:0]   r_cache_rdata;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [LADDR_W-1:0]  r_mem_addr;
    logic [LINE_W-1:0]   r_mem_wdata;

    logic                w_hit;
    logic [PW-1:0]       w_hit_idx;
    logic [LINE_W-1:0]   w_hit_data;
    logic [LADDR_W-1:0]  w_head_addr;
    logic [LINE_W-1:0]   w_head_data;
    logic                w_full;
    logic                w_empty;
    logic                w_arb;
    logic                w_rd;
    logic                w_wr;
    logic                w_rd_hit;
    logic                w_rd_miss;
    logic                w_ovr;
    logic                w_push;
    logic                w_wr_done;
    logic                w_drain_go;
    logic                w_pop;

    // The cache still holds its request during the ready pulse,
    // so that cycle makes no decision at all.
    assign w_arb      = (r_state == IDLE) && !r_cache_ready;
    assign w_rd       = w_arb && cache_read;
    assign w_wr       = w_arb && !cache_read && cache_write;
    assign w_rd_hit   = w_rd && w_hit;
    assign w_rd_miss  = w_rd && !w_hit;
    assign w_ovr      = w_wr && w_hit;
    assign w_push     = w_wr && !w_hit && !w_full;
    assign w_wr_done  = w_ovr || w_push;
    assign w_drain_go = w_arb && !w_rd && !w_wr_done && !w_empty;
    assign w_pop      = (r_state == DRAIN) && mem_ready;

    dwb_store #(
        .DEPTH (DEPTH)
    ) u_store (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_addr  (cache_addr),
        .i_push_data  (cache_wdata),
        .i_pop        (w_pop),
        .i_ovr        (w_ovr),
        .i_ovr_idx    (w_hit_idx),
        .i_ovr_data   (cache_wdata),
        .i_match_addr (cache_addr),
        .o_hit        (w_hit),
        .o_hit_idx    (w_hit_idx),
        .o_hit_data   (w_hit_data),
        .o_head_addr  (w_head_addr),
        .o_head_data  (w_head_data),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    // Control FSM with registered cache and memory outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cache_ready <= 1'b0;
            r_cache_rdata <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
        end else begin
            r_cache_ready <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    unique case (1'b1)
                        w_rd_hit: begin
                            r_cache_rdata <= w_hit_data;
                            r_cache_ready <= 1'b1;
                        end
                        w_rd_miss: begin
                            r_mem_read <= 1'b1;
                            r_mem_addr <= cache_addr;
                            r_state    <= READ;
                        end
                        w_wr_done: begin
                            r_cache_ready <= 1'b1;
                        end
                        w_drain_go: begin
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= w_head_addr;
                            r_mem_wdata <= w_head_data;
                            r_state     <= DRAIN;
                        end
                        default: ;
                    endcase
                end
                READ: begin
                    if (mem_ready) begin
                        r_mem_read    <= 1'b0;
                        r_cache_rdata <= mem_rdata;
                        r_cache_ready <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                DRAIN: begin
                    if (mem_ready) begin
                        r_mem_write <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cache_ready = r_cache_ready;
    assign cache_rdata = r_cache_rdata;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Bench for dcache_write_buffer: queue-based reference model,
// per-cycle output compare, directed scenarios and random traffic.
module tb_dcache_write_buffer;

    localparam int DEPTH = 4;

    logic         clk;
    logic         rst_n;
    logic         cache_read;
    logic         cache_write;
    logic [27:0]  cache_addr;
    logic [127:0] cache_wdata;
    logic [127:0] cache_rdata;
    logic         cache_ready;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int checks = 0;
    int fails  = 0;

    dcache_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cache_read  (cache_read),
        .cache_write (cache_write),
        .cache_addr  (cache_addr),
        .cache_wdata (cache_wdata),
        .cache_rdata (cache_rdata),
        .cache_ready (cache_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // mode: 0 no memory op, 1 read outstanding, 2 write-back outstanding
    int            m_mode;
    logic [27:0]   qa[$];
    logic [127:0]  qd[$];
    logic          e_ready;
    logic [127:0]  e_rdata;
    logic          e_mrd;
    logic          e_mwr;
    logic [27:0]   e_maddr;
    logic [127:0]  e_mwdata;

    function automatic int find(input logic [27:0] a);
        for (int i = 0; i < qa.size(); i++)
            if (qa[i] == a) return i;
        return -1;
    endfunction

    task automatic model_start_drain();
        e_mwr    = 1'b1;
        e_maddr  = qa[0];
        e_mwdata = qd[0];
        m_mode   = 2;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mode = 0;
                qa.delete();
                qd.delete();
                e_ready = 0; e_rdata = '0; e_mrd = 0;
                e_mwr = 0; e_maddr = '0; e_mwdata = '0;
            end else begin
                logic busy_ack;
                int   idx;
                busy_ack = e_ready;
                e_ready  = 1'b0;
                if (m_mode == 0 && !busy_ack) begin
                    if (cache_read) begin
                        idx = find(cache_addr);
                        if (idx >= 0) begin
                            e_rdata = qd[idx];
                            e_ready = 1'b1;
                        end else begin
                            e_mrd   = 1'b1;
                            e_maddr = cache_addr;
                            m_mode  = 1;
                        end
                    end else if (cache_write) begin
                        idx = find(cache_addr);
                        if (idx >= 0) begin
                            qd[idx] = cache_wdata;
                            e_ready = 1'b1;
                        end else if (qa.size() < DEPTH) begin
                            qa.push_back(cache_addr);
                            qd.push_back(cache_wdata);
                            e_ready = 1'b1;
                        end else begin
                            model_start_drain();
                        end
                    end else if (qa.size() > 0) begin
                        model_start_drain();
                    end
                end else if (m_mode == 1 && mem_ready) begin
                    e_mrd   = 1'b0;
                    e_rdata = mem_rdata;
                    e_ready = 1'b1;
                    m_mode  = 0;
                end else if (m_mode == 2 && mem_ready) begin
                    e_mwr = 1'b0;
                    void'(qa.pop_front());
                    void'(qd.pop_front());
                    m_mode = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checks++;
                if ({cache_ready, cache_rdata, mem_read, mem_write,
                     mem_addr, mem_wdata} !==
                    {e_ready, e_rdata, e_mrd, e_mwr, e_maddr, e_mwdata}) begin
                    fails++;
                    $display("FAIL cycle t=%0t got rdy=%b rd=%h mr=%b mw=%b ma=%h md=%h exp rdy=%b rd=%h mr=%b mw=%b ma=%h md=%h",
                             $time, cache_ready, cache_rdata, mem_read,
                             mem_write, mem_addr, mem_wdata, e_ready,
                             e_rdata, e_mrd, e_mwr, e_maddr, e_mwdata);
                end
            end
        end
    end

    // ---------------- memory op log ----------------
    bit            op_rd[$];
    logic [27:0]   op_addr[$];
    logic [127:0]  op_data[$];

    initial begin
        logic pr, pw;
        pr = 0; pw = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pr = 0; pw = 0;
            end else begin
                if (mem_read && !pr) begin
                    op_rd.push_back(1'b1);
                    op_addr.push_back(mem_addr);
                    op_data.push_back('0);
                end
                if (mem_write && !pw) begin
                    op_rd.push_back(1'b0);
                    op_addr.push_back(mem_addr);
                    op_data.push_back(mem_wdata);
                end
                pr = mem_read;
                pw = mem_write;
            end
        end
    end

    // ---------------- slow memory responder ----------------
    int           lat = 3;
    logic [127:0] last_mrdata;

    initial begin
        int wcnt;
        wcnt = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (rst_n && (mem_read || mem_write)) begin
                wcnt++;
                if (wcnt >= lat) begin
                    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                    last_mrdata = mem_rdata;
                    mem_ready = 1'b1;
                    wcnt = 0;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [287:0] act,
                       input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that
    // ends the ready cycle, with the request already dropped.
    task automatic do_req(input bit rd, input logic [27:0] a,
                          input logic [127:0] d, output int waited,
                          output logic [127:0] rdat);
        bit got;
        cache_read  = rd;
        cache_write = !rd;
        cache_addr  = a;
        cache_wdata = d;
        waited = 0;
        got = 0;
        rdat = '0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            waited++;
            got = cache_ready;
        end
        checks++;
        if (!got) begin
            fails++;
            $display("FAIL req_timeout addr=%h got no ready exp ready", a);
        end
        rdat = cache_rdata;
        @(posedge clk);
        #1;
        cache_read  = 0;
        cache_write = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((qa.size() != 0 || m_mode != 0 || e_ready) && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 600) begin
            fails++;
            $display("FAIL idle_timeout got busy exp idle");
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int           w;
        int           base;
        logic [127:0] r;
        logic [127:0] da;
        logic [127:0] db;

        rst_n = 0;
        cache_read = 0; cache_write = 0;
        cache_addr = '0; cache_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {cache_ready, cache_rdata, mem_read,
            mem_write, mem_addr, mem_wdata}, '0);
        rst_n = 1;
        @(posedge clk);
        #1;

        // write then read hit, no memory traffic
        base = op_rd.size();
        da = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        do_req(0, 28'h0000100, da, w, r);
        chk("t1_wr_lat", w, 2);
        do_req(1, 28'h0000100, '0, w, r);
        chk("t1_rd_lat", w, 2);
        chk("t1_rd_data", r, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
        chk("t1_no_mem", op_rd.size(), base);
        wait_idle();

        // coalescing
        base = op_rd.size();
        da = {4{32'hAAAA_0001}};
        db = {4{32'hBBBB_0002}};
        do_req(0, 28'h0000200, da, w, r);
        do_req(0, 28'h0000200, db, w, r);
        wait_idle();
        chk("t2_ndrain", op_rd.size() - base, 1);
        chk("t2_addr", op_addr[base], 28'h0000200);
        chk("t2_data", op_data[base], {4{32'hBBBB_0002}});

        // full buffer plus write miss, FIFO order across wrap
        lat = 5;
        base = op_rd.size();
        for (int i = 0; i < 4; i++)
            do_req(0, 28'h0000400 + 28'(i), {4{32'hA0 + 32'(i)}}, w, r);
        do_req(0, 28'h0000404, {4{32'hA4}}, w, r);
        chk("t3_full_lat", w, 8);
        wait_idle();
        chk("t3_ndrain", op_rd.size() - base, 5);
        for (int i = 0; i < 5; i++) begin
            chk("t3_order_addr", op_addr[base+i], 28'h0000400 + 28'(i));
            chk("t3_order_data", op_data[base+i], {4{32'hA0 + 32'(i)}});
        end

        // read miss ahead of pending drains
        lat = 7;
        base = op_rd.size();
        for (int i = 0; i < 3; i++)
            do_req(0, 28'h0000310 + 28'(i), {4{32'hC0 + 32'(i)}}, w, r);
        do_req(1, 28'h0000300, '0, w, r);
        chk("t4_miss_lat", w, 9);
        chk("t4_first_is_read", op_rd[base], 1'b1);
        chk("t4_read_addr", op_addr[base], 28'h0000300);
        chk("t4_rdata", r, last_mrdata);
        wait_idle();
        chk("t4_ndrain", op_rd.size() - base, 4);
        for (int i = 0; i < 3; i++)
            chk("t4_intact", op_addr[base+1+i], 28'h0000310 + 28'(i));

        // write arriving during a drain of the same line
        lat = 4;
        base = op_rd.size();
        do_req(0, 28'h0000500, {4{32'hD5}}, w, r);
        repeat (2) @(posedge clk);
        #1;
        do_req(0, 28'h0000500, {4{32'hD6}}, w, r);
        chk("t5_stall_lat", w, 5);
        wait_idle();
        chk("t5_ndrain", op_rd.size() - base, 2);
        chk("t5_first", op_data[base], {4{32'hD5}});
        chk("t5_second", op_data[base+1], {4{32'hD6}});

        // asynchronous reset during an outstanding read
        lat = 20;
        do_req(0, 28'h0000600, {4{32'hE6}}, w, r);
        cache_read = 1;
        cache_addr = 28'h0000700;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk("t6_async_clear", {cache_ready, cache_rdata, mem_read,
            mem_write, mem_addr, mem_wdata}, '0);
        cache_read = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        lat = 2;
        base = op_rd.size();
        repeat (8) @(posedge clk);
        #1;
        chk("t6_no_drain", op_rd.size(), base);
        do_req(1, 28'h0000600, '0, w, r);
        chk("t6_miss_after_reset", op_rd[base], 1'b1);
        wait_idle();

        // random traffic
        for (int n = 0; n < 250; n++) begin
            lat = int'($urandom_range(1, 6));
            do_req($urandom_range(0, 9) < 4,
                   28'h0000800 + 28'($urandom_range(0, 7)),
                   {$urandom, $urandom, $urandom, $urandom}, w, r);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            if ($time % 10 != 1) #1;
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/dcache_write_buffer.md
# dcache_write_buffer

Line-granular write buffer between the D-cache memory port and slow data memory. It presents the same request/ready protocol as slow memory toward the cache. Dirty-line write-backs complete in one cycle, and the buffer drains them to memory in the background. Reads that hit a buffered line are forwarded locally; read misses bypass the buffered writes.

## Interface
Parameters:
- DEPTH, 4, number of 128-bit line entries (power of two, 2..8)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cache_read  in  1  line read request from D-cache, held until cache_ready
- cache_write  in  1  line write request from D-cache, held until cache_ready
- cache_addr  in  28  line address [31:4]
- cache_wdata  in  128  write line data
- cache_rdata  out  128  read line data, valid while cache_ready=1
- cache_ready  out  1  one-cycle completion pulse
- mem_read  out  1  read request to slow memory, held until mem_ready
- mem_write  out  1  write request to slow memory, held until mem_ready
- mem_addr  out  28  line address [31:4]
- mem_wdata  out  128  write line data
- mem_rdata  in  128  memory read data, valid with mem_ready
- mem_ready  in  1  one-cycle memory completion pulse

## Operation
- Storage: DEPTH entries {valid, addr[27:0], data[127:0]}, kept as a circular FIFO with head/tail pointers and a count of 0..DEPTH.
- FSM states:
  - IDLE: no memory transaction outstanding.
  - READ: mem_read outstanding.
  - DRAIN: mem_write of the head entry outstanding.
- Arbitration in IDLE, in strict priority order:
  1. Cache read.
  2. Cache write.
  3. Drain when count>0.
- Cache write in IDLE:
  - Address matches a valid entry: overwrite that entry's data (coalesce); count unchanged.
  - No match and count<DEPTH: push at tail, count+1.
  - No match and count==DEPTH: go to DRAIN on the head entry; the write is serviced after the drain completes.
- Cache read in IDLE:
  - Address matches a valid entry: cache_rdata = entry data; no memory access.
  - Miss: mem_read of cache_addr, state READ. On mem_ready, capture mem_rdata and return it to the cache; next state IDLE.
- Entry addresses are unique because of coalescing, so at most one entry matches.
- DRAIN:
  - mem_addr/mem_wdata come from the head entry and are registered at DRAIN entry.
  - On mem_ready: pop the head (valid=0, head+1 mod DEPTH, count-1); next state IDLE.
  - Cache requests arriving during DRAIN wait; the head is never modified while draining.
- Memory transactions are never aborted once issued.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values: cache_ready=0, cache_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, state=IDLE, count=0, all valid=0, head=tail=0.
- Reset mid-transaction drops the request immediately and discards buffered data.
- All outputs are registered.
- Request accepted in cycle t.
- Write, or read hit: cache_ready=1 in cycle t+1 for exactly one cycle.
- Read miss:
  - mem_read rises at t+1 and is held until the mem_ready cycle m.
  - mem_read drops at m+1; cache_ready and cache_rdata are valid at m+1.
- Drain: mem_write rises the cycle after the IDLE decision. It drops, and the pop takes effect, the cycle after mem_ready.
- Cache requests are ignored in the cycle cache_ready=1, because the cache is still holding the request then; this prevents double acceptance.
- Full buffer plus write miss: cache_ready occurs 1 cycle after the drain's pop.
- Simultaneous read and write requests do not occur; if both are asserted, read wins.

## Structure
- Package dwb_pkg:
  - state enum {IDLE, READ, DRAIN}
  - LINE_W=128, LADDR_W=28
  - entry struct type
- Sub-module dwb_store: entry array, head/tail/count, push/pop/overwrite ports, combinational match output (hit, index).
- The top level holds the FSM and output registers.

## Test plan
- Write to 0x0000100 then read from 0x0000100 → cache_ready at t+1 both times; read returns the written data; mem_read never asserts.
- Two writes to 0x0000200 (data A then B) → count=1; drain issues a single mem_write at 0x0000200 with B.
- Fill 4 distinct addresses, then write a fifth → drain of the first entry with mem_ready after 5 cycles, then cache_ready; count=4; FIFO order preserved across head/tail wrap.
- Read miss at 0x0000300 with 3 buffered writes and mem_ready after 7 cycles → mem_read is issued before any drain; cache_rdata equals mem_rdata; buffer intact.
- Cache write arrives during DRAIN → stalls until pop; drained data unchanged; new write completes afterward.
- Deassert rst_n during READ → all outputs 0 asynchronously; count=0 after release.
